// File: rtl/core_rf_pkg.sv
// Shared constants for the architectural register file and its scoreboard.
package core_rf_pkg;

    // Default geometry: 128 registers of 32 bits, 7-bit register addresses.
    localparam int unsigned DEF_NREG = 128;
    localparam int unsigned DEF_AW   = 7;
    localparam int unsigned DEF_DW   = 32;

    // Read-port indices as seen by the dual-issue operand-fetch stage.
    localparam int unsigned NUM_RD_PORTS = 4;
    localparam int unsigned RP_A_RS1     = 0;
    localparam int unsigned RP_A_RS2     = 1;
    localparam int unsigned RP_B_RS1     = 2;
    localparam int unsigned RP_B_RS2     = 3;

    // Register-class boundaries: 1..31 integer, 32 and up FP/CSR shadow.
    localparam int unsigned INT_LAST = 31;
    localparam int unsigned FP_FIRST = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: set on issue, clear on writeback (set wins),
// busy lookup for the four read ports and a registered pending count.
// Optional macro WB_BYPASS_EN suppresses busy for addresses written this cycle.
module rf_scoreboard
    import core_rf_pkg::*;
#(
    parameter int unsigned NREG = DEF_NREG,
    parameter int unsigned AW   = DEF_AW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              iss_en,
    input  logic [AW-1:0]           iss_add0,
    input  logic [AW-1:0]           iss_add1,
    input  logic                    wr_en1,
    input  logic [AW-1:0]           wr_add1,
    input  logic                    wr_en2,
    input  logic [AW-1:0]           wr_add2,
    input  logic [NUM_RD_PORTS-1:0] rd_en,
    input  logic [AW-1:0]           rd_add0,
    input  logic [AW-1:0]           rd_add1,
    input  logic [AW-1:0]           rd_add2,
    input  logic [AW-1:0]           rd_add3,
    output logic [NUM_RD_PORTS-1:0] rd_busy,
    output logic [AW:0]             pend_cnt
);

    logic [NREG-1:0] pending_q, pending_d;
    logic [NREG-1:0] set_vec, clr_vec;
    logic [AW:0]     pend_cnt_q, pend_cnt_d;
    logic [AW-1:0]   rd_add [NUM_RD_PORTS];

    // Next pending vector: clears first, then sets so a new producer supersedes.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (wr_en1) clr_vec[wr_add1] = 1'b1;
        if (wr_en2) clr_vec[wr_add2] = 1'b1;
        if (iss_en[0] && (iss_add0 != '0)) set_vec[iss_add0] = 1'b1;
        if (iss_en[1] && (iss_add1 != '0)) set_vec[iss_add1] = 1'b1;
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    // Population count of the next pending vector; at most NREG-1 so never wraps.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pending_d[i]};
        end
    end

    // Busy lookup against the current (pre-edge) pending state.
    always_comb begin
        rd_add[RP_A_RS1] = rd_add0;
        rd_add[RP_A_RS2] = rd_add1;
        rd_add[RP_B_RS1] = rd_add2;
        rd_add[RP_B_RS2] = rd_add3;
        rd_busy = '0;
        for (int k = 0; k < int'(NUM_RD_PORTS); k++) begin
            rd_busy[k] = rd_en[k] & pending_q[rd_add[k]] & (rd_add[k] != '0);
`ifdef WB_BYPASS_EN
            // The landing writeback is forwarded, so no stall is needed.
            if ((wr_en1 && (wr_add1 == rd_add[k])) || (wr_en2 && (wr_add2 == rd_add[k]))) begin
                rd_busy[k] = 1'b0;
            end
`endif
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file: two writeback ports (port 2 younger, wins),
// four registered read ports, r0 hardwired to zero, plus RAW scoreboard.
// Optional macro WB_BYPASS_EN forwards same-cycle writes into the read data.
module wb_regfile
    import core_rf_pkg::*;
#(
    parameter int unsigned NREG = DEF_NREG,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned DW   = DEF_DW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en1,
    input  logic [AW-1:0]           wr_add1,
    input  logic [DW-1:0]           wr_data1,
    input  logic                    wr_en2,
    input  logic [AW-1:0]           wr_add2,
    input  logic [DW-1:0]           wr_data2,
    input  logic [NUM_RD_PORTS-1:0] rd_en,
    input  logic [AW-1:0]           rd_add0,
    input  logic [AW-1:0]           rd_add1,
    input  logic [AW-1:0]           rd_add2,
    input  logic [AW-1:0]           rd_add3,
    output logic [DW-1:0]           rd_data0,
    output logic [DW-1:0]           rd_data1,
    output logic [DW-1:0]           rd_data2,
    output logic [DW-1:0]           rd_data3,
    input  logic [1:0]              iss_en,
    input  logic [AW-1:0]           iss_add0,
    input  logic [AW-1:0]           iss_add1,
    output logic [NUM_RD_PORTS-1:0] rd_busy,
    output logic [AW:0]             pend_cnt
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];
    logic [DW-1:0] rd_data_q [NUM_RD_PORTS];
    logic [DW-1:0] rd_data_d [NUM_RD_PORTS];
    logic [DW-1:0] rd_val [NUM_RD_PORTS];
    logic [AW-1:0] rd_add [NUM_RD_PORTS];

    // Array update: port 1 then port 2 so the younger result lands last; r0 is never written.
    always_comb begin
        mem_d = mem_q;
        if (wr_en1 && (wr_add1 != '0)) mem_d[wr_add1] = wr_data1;
        if (wr_en2 && (wr_add2 != '0)) mem_d[wr_add2] = wr_data2;
    end

    // Read value per port, optionally forwarding this cycle's writeback.
    always_comb begin
        rd_add[RP_A_RS1] = rd_add0;
        rd_add[RP_A_RS2] = rd_add1;
        rd_add[RP_B_RS1] = rd_add2;
        rd_add[RP_B_RS2] = rd_add3;
        for (int k = 0; k < int'(NUM_RD_PORTS); k++) begin
            rd_val[k] = mem_q[rd_add[k]];
`ifdef WB_BYPASS_EN
            if (wr_en2 && (wr_add2 == rd_add[k])) begin
                rd_val[k] = wr_data2;
            end else if (wr_en1 && (wr_add1 == rd_add[k])) begin
                rd_val[k] = wr_data1;
            end
`endif
            if (rd_add[k] == '0) rd_val[k] = '0;
            rd_data_d[k] = rd_en[k] ? rd_val[k] : rd_data_q[k];
        end
    end

    // Array and read-data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
            for (int k = 0; k < int'(NUM_RD_PORTS); k++) rd_data_q[k] <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data0 = rd_data_q[RP_A_RS1];
    assign rd_data1 = rd_data_q[RP_A_RS2];
    assign rd_data2 = rd_data_q[RP_B_RS1];
    assign rd_data3 = rd_data_q[RP_B_RS2];

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_add0 (iss_add0),
        .iss_add1 (iss_add1),
        .wr_en1   (wr_en1),
        .wr_add1  (wr_add1),
        .wr_en2   (wr_en2),
        .wr_add2  (wr_add2),
        .rd_en    (rd_en),
        .rd_add0  (rd_add0),
        .rd_add1  (rd_add1),
        .rd_add2  (rd_add2),
        .rd_add3  (rd_add3),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en1, wr_en2;
    logic [6:0]  wr_add1, wr_add2;
    logic [31:0] wr_data1, wr_data2;
    logic [3:0]  rd_en;
    logic [6:0]  rd_add0, rd_add1, rd_add2, rd_add3;
    logic [31:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic [1:0]  iss_en;
    logic [6:0]  iss_add0, iss_add1;
    logic [3:0]  rd_busy;
    logic [7:0]  pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en1   (wr_en1),
        .wr_add1  (wr_add1),
        .wr_data1 (wr_data1),
        .wr_en2   (wr_en2),
        .wr_add2  (wr_add2),
        .wr_data2 (wr_data2),
        .rd_en    (rd_en),
        .rd_add0  (rd_add0),
        .rd_add1  (rd_add1),
        .rd_add2  (rd_add2),
        .rd_add3  (rd_add3),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_data3 (rd_data3),
        .iss_en   (iss_en),
        .iss_add0 (iss_add0),
        .iss_add1 (iss_add1),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt)
    );

    logic [31:0] act_rd [4];
    assign act_rd[0] = rd_data0;
    assign act_rd[1] = rd_data1;
    assign act_rd[2] = rd_data2;
    assign act_rd[3] = rd_data3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_en1 = 0; wr_add1 = 0; wr_data1 = 0;
        wr_en2 = 0; wr_add2 = 0; wr_data2 = 0;
        rd_en = 0; rd_add0 = 0; rd_add1 = 0; rd_add2 = 0; rd_add3 = 0;
        iss_en = 0; iss_add0 = 0; iss_add1 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    // Directed vector: one cycle of stimulus plus expected port-0 busy/data and count.
    typedef struct {
        logic        we1;
        logic [6:0]  wa1;
        logic [31:0] wd1;
        logic        we2;
        logic [6:0]  wa2;
        logic [31:0] wd2;
        logic        re0;
        logic [6:0]  ra0;
        logic [1:0]  iss;
        logic [6:0]  ia0;
        logic [6:0]  ia1;
        logic        exp_busy0;
        logic [31:0] exp_rd0;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [12];

    // Behavioural reference model.
    logic [31:0] m_mem [128];
    bit          m_pend [128];
    logic [31:0] m_rd [4];

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 128; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic logic [6:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 7'($urandom_range(0, 127));
        return 7'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [6:0]  ra [4];
        logic [3:0]  exp_busy;
        logic [31:0] nxt_rd [4];

        reset = 1'b0;
        idle_inputs();
        #12;
        check("reset_rd_data0", rd_data0, 32'h0);
        check("reset_rd_busy", 32'(rd_busy), 32'h0);
        check("reset_pend_cnt", 32'(pend_cnt), 32'h0);
        reset = 1'b1;
        step();

        // we1 wa1 wd1 | we2 wa2 wd2 | re0 ra0 | iss ia0 ia1 | busy0 rd0 cnt
        vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,     0, 0,  2'b00, 0,  0,  0, 32'h0,        8'd0};
        vecs[1]  = '{0, 0,  0,            0, 0,  0,     1, 5,  2'b00, 0,  0,  0, 32'hDEADBEEF, 8'd0};
        vecs[2]  = '{1, 7,  32'h11,       1, 7,  32'h22, 0, 0, 2'b00, 0,  0,  0, 32'hDEADBEEF, 8'd0};
        vecs[3]  = '{0, 0,  0,            0, 0,  0,     1, 7,  2'b00, 0,  0,  0, 32'h22,       8'd0};
        vecs[4]  = '{1, 0,  32'hFFFF,     0, 0,  0,     0, 0,  2'b01, 0,  0,  0, 32'h22,       8'd0};
        vecs[5]  = '{0, 0,  0,            0, 0,  0,     1, 0,  2'b00, 0,  0,  0, 32'h0,        8'd0};
        vecs[6]  = '{0, 0,  0,            0, 0,  0,     0, 0,  2'b01, 12, 0,  0, 32'h0,        8'd1};
        vecs[7]  = '{1, 12, 32'h77,       0, 0,  0,     1, 12, 2'b01, 12, 0,
                     !BYP, BYP ? 32'h77 : 32'h0, 8'd1};
        vecs[8]  = '{0, 0,  0,            0, 0,  0,     1, 12, 2'b00, 0,  0,  1, 32'h77,       8'd1};
        vecs[9]  = '{0, 0,  0,            1, 12, 32'h99, 1, 12, 2'b00, 0, 0,
                     !BYP, BYP ? 32'h99 : 32'h77, 8'd0};
        vecs[10] = '{0, 0,  0,            0, 0,  0,     0, 0,  2'b11, 20, 20,
                     0, BYP ? 32'h99 : 32'h77, 8'd1};
        vecs[11] = '{1, 20, 32'h5,        0, 0,  0,     1, 20, 2'b11, 21, 22,
                     !BYP, BYP ? 32'h5 : 32'h0, 8'd2};

        for (int v = 0; v < 12; v++) begin
            idle_inputs();
            wr_en1 = vecs[v].we1; wr_add1 = vecs[v].wa1; wr_data1 = vecs[v].wd1;
            wr_en2 = vecs[v].we2; wr_add2 = vecs[v].wa2; wr_data2 = vecs[v].wd2;
            rd_en = {3'b000, vecs[v].re0}; rd_add0 = vecs[v].ra0;
            iss_en = vecs[v].iss; iss_add0 = vecs[v].ia0; iss_add1 = vecs[v].ia1;
            #1;
            check($sformatf("vec%0d_busy0", v), 32'(rd_busy[0]), 32'(vecs[v].exp_busy0));
            step();
            check($sformatf("vec%0d_rd0", v), rd_data0, vecs[v].exp_rd0);
            check($sformatf("vec%0d_cnt", v), 32'(pend_cnt), 32'(vecs[v].exp_cnt));
        end

        // RAW on lane B rs1: busy until the writeback, then forwarded or one cycle later.
        idle_inputs();
        iss_en = 2'b01; iss_add0 = 9;
        step();
        idle_inputs();
        rd_en = 4'b0100; rd_add2 = 9;
        #1;
        check("raw_busy_before_wb", 32'(rd_busy[2]), 32'h1);
        step();
        wr_en2 = 1; wr_add2 = 9; wr_data2 = 32'h5;
        #1;
        check("raw_busy_wb_cycle", 32'(rd_busy[2]), 32'(!BYP));
        step();
        check("raw_data_wb_cycle", rd_data2, BYP ? 32'h5 : 32'h0);
        idle_inputs();
        rd_en = 4'b0100; rd_add2 = 9;
        #1;
        check("raw_busy_after_wb", 32'(rd_busy[2]), 32'h0);
        step();
        check("raw_data_after_wb", rd_data2, 32'h5);

        // Asynchronous reset in the middle of a cycle with r3/r4 pending.
        idle_inputs();
        iss_en = 2'b11; iss_add0 = 3; iss_add1 = 4;
        step();
        idle_inputs();
        rd_en = 4'b0011; rd_add0 = 3; rd_add1 = 4;
        #1;
        check("pre_reset_busy", 32'(rd_busy[1:0]), 32'h3);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_busy", 32'(rd_busy), 32'h0);
        check("async_reset_cnt", 32'(pend_cnt), 32'h0);
        check("async_reset_rd2", rd_data2, 32'h0);
        check("async_reset_rd0", rd_data0, 32'h0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        step();
        // Late result after reset still writes the array but tracks nothing.
        wr_en1 = 1; wr_add1 = 3; wr_data1 = 32'hABC;
        step();
        check("late_wb_cnt", 32'(pend_cnt), 32'h0);
        idle_inputs();
        rd_en = 4'b1000; rd_add3 = 3;
        #1;
        check("late_wb_busy", 32'(rd_busy[3]), 32'h0);
        step();
        check("late_wb_data", rd_data3, 32'hABC);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) m_rd[k] = '0;

        for (int c = 0; c < 400; c++) begin
            wr_en1 = 1'($urandom_range(0, 1)); wr_add1 = rnd_addr(); wr_data1 = $urandom;
            wr_en2 = 1'($urandom_range(0, 1)); wr_add2 = rnd_addr(); wr_data2 = $urandom;
            rd_en = 4'($urandom);
            ra[0] = rnd_addr(); ra[1] = rnd_addr(); ra[2] = rnd_addr(); ra[3] = rnd_addr();
            rd_add0 = ra[0]; rd_add1 = ra[1]; rd_add2 = ra[2]; rd_add3 = ra[3];
            iss_en = 2'($urandom); iss_add0 = rnd_addr(); iss_add1 = rnd_addr();
            #1;
            for (int k = 0; k < 4; k++) begin
                bool_wr_hit: begin
                    bit hit;
                    hit = (wr_en1 && wr_add1 == ra[k]) || (wr_en2 && wr_add2 == ra[k]);
                    exp_busy[k] = rd_en[k] && ra[k] != 0 && m_pend[ra[k]] && !(BYP && hit);
                end
                if (!rd_en[k]) nxt_rd[k] = m_rd[k];
                else if (ra[k] == 0) nxt_rd[k] = 32'h0;
                else if (BYP && wr_en2 && wr_add2 == ra[k]) nxt_rd[k] = wr_data2;
                else if (BYP && wr_en1 && wr_add1 == ra[k]) nxt_rd[k] = wr_data1;
                else nxt_rd[k] = m_mem[ra[k]];
            end
            check("rand_busy", 32'(rd_busy), 32'(exp_busy));
            if (wr_en1 && wr_add1 != 0) m_mem[wr_add1] = wr_data1;
            if (wr_en2 && wr_add2 != 0) m_mem[wr_add2] = wr_data2;
            if (wr_en1) m_pend[wr_add1] = 1'b0;
            if (wr_en2) m_pend[wr_add2] = 1'b0;
            if (iss_en[0] && iss_add0 != 0) m_pend[iss_add0] = 1'b1;
            if (iss_en[1] && iss_add1 != 0) m_pend[iss_add1] = 1'b1;
            m_pend[0] = 1'b0;
            for (int k = 0; k < 4; k++) m_rd[k] = nxt_rd[k];
            step();
            for (int k = 0; k < 4; k++) check($sformatf("rand_rd%0d", k), act_rd[k], m_rd[k]);
            check("rand_cnt", 32'(pend_cnt), 32'(m_count()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural register file and scoreboard; consumes the two merged writeback ports produced by the writeback merge stage.
- Holds NREG x DW registers:
  - index 0 is hardwired zero;
  - 1-31 integer;
  - 32-127 reserved for FP/CSR shadow.
- Serves four registered read ports to the dual-issue operand-fetch stage (lane A rs1/rs2, lane B rs1/rs2).
- Tracks in-flight destinations so issue can stall on RAW hazards.

Parameters:
- NREG, 128, number of registers
- AW, 7, register address width (log2 NREG)
- DW, 32, data width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- wr_en1  in  1  write port 1 valid (older result)
- wr_add1  in  AW  write port 1 address
- wr_data1  in  DW  write port 1 data
- wr_en2  in  1  write port 2 valid (younger result)
- wr_add2  in  AW  write port 2 address
- wr_data2  in  DW  write port 2 data
- rd_en[3:0]  in  4  read port enables (0=A.rs1, 1=A.rs2, 2=B.rs1, 3=B.rs2)
- rd_add0..rd_add3  in  AW each  read addresses
- rd_data0..rd_data3  out  DW each  registered read data
- iss_en[1:0]  in  2  lane A/B issuing an instruction with a destination
- iss_add0, iss_add1  in  AW each  destination of lane A/B
- rd_busy[3:0]  out  4  combinational: read address currently pending
- pend_cnt  out  AW+1  number of pending destinations

Behaviour:
- Reset (reset=0, async):
  - array cleared;
  - pending vector cleared;
  - rd_data0..3 = 0, rd_busy = 0, pend_cnt = 0.
- Write:
  - on posedge clk, wr_enN with wr_addN != 0 writes wr_dataN.
  - Both ports to the same address: port 2 wins (younger).
  - Writes to address 0 are discarded.
- Read:
  - 1-cycle latency; rd_dataK registers array[rd_addK] when rd_en[K]=1, else holds its previous value.
  - rd_addK = 0 returns 0.
- Scoreboard set:
  - iss_en[i] with iss_addi != 0 sets pending[iss_addi] on the clock edge.
  - Lane A and B to the same address: a single set.
- Scoreboard clear:
  - wr_enN clears pending[wr_addN].
  - Set and clear of the same address in the same cycle: set wins (new producer supersedes).
- rd_busy[K]:
  - = rd_en[K] & pending[rd_addK] & (rd_addK != 0), evaluated on the current pending state.
  - Without bypass, a write landing in this cycle does not clear busy until the next cycle.
- pend_cnt:
  - registered population count of pending;
  - updated every cycle as +sets -clears, with set-wins applied;
  - saturation impossible since count <= NREG-1.
- Write-after-write with no intervening read is legal: last write wins, pending cleared by the first write unless re-set.
- Reset mid-operation: all pending cleared; in-flight results that arrive later still write the array (no hazard tracking for them).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - a same-cycle write to rd_addK forwards into rd_dataK (port 2 over port 1 over array);
  - rd_busy[K] is suppressed when the pending address is being written this cycle by either port;
  - saves one stall cycle per RAW.
- Undefined:
  - rd_dataK reads the pre-write array value;
  - rd_busy holds for that cycle.

Decomposition:
- Shared package core_rf_pkg:
  - NREG/AW/DW defaults;
  - the read-port index constants (RP_A_RS1..RP_B_RS2);
  - the register-class boundary constants (INT_LAST=31, FP_FIRST=32).
- Natural sub-module rf_scoreboard: pending vector, set/clear priority, busy lookup and pend_cnt.
- The array and read/bypass logic stay in the top.

Test Plan:
1. Write 0xDEADBEEF to r5 via port 1, then read r5 on port 0 the next cycle -> rd_data0=0xDEADBEEF one cycle after rd_en.
2. Same cycle: port 1 writes r7=0x11, port 2 writes r7=0x22 -> subsequent read of r7 returns 0x22.
3. Write 0xFFFF to r0, then read r0 -> rd_data=0; iss to r0 -> pend_cnt stays 0.
4. iss_en[0] r9, then read r9 -> rd_busy=1; wr_en2 r9=0x5 ->
   - bypass on: busy=0 and rd_data=0x5 in that cycle;
   - bypass off: busy=0 next cycle.
5. Same cycle: iss r12 and wr r12 -> pending[12]=1, pend_cnt unchanged.
6. Set pending on r3 and r4, assert reset low asynchronously mid-cycle -> rd_busy=0, pend_cnt=0, rd_data=0 immediately.
